del_lfo: RTL and testbench
==========================

Name: del_lfo

Overview:
- Modulation source that drives the delay-tap input of the variable delay line, for chorus, flanger and vibrato effects.
- Generates a triangle LFO stepped once per audio sample, scales it by depth, adds a base delay and emits a bounded delay value with a valid strobe.
- Sits between the control-register block and the delay line, in the same sample-valid domain as the audio path.

Parameters:
- BUFR_DEPTH, 512, depth of the target delay buffer; DEL_WIDTH = $clog2(BUFR_DEPTH).
- ACC_WIDTH, 16, width of the triangle accumulator; MAX = 2^ACC_WIDTH-1.
- RATE_WIDTH, 8, width of the per-sample LFO step.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- vld_i  in  1  one-cycle audio sample strobe; advances the LFO.
- en  in  1  modulation enable; 0 outputs static base delay.
- rate  in  RATE_WIDTH  triangle step per sample, unsigned.
- depth  in  DEL_WIDTH  peak modulation excursion in samples, unsigned.
- base  in  DEL_WIDTH  centre/minimum delay in samples, unsigned.
- del_o  out  DEL_WIDTH  delay value for the delay line.
- del_vld  out  1  one-cycle pulse, high when del_o is updated.

Behaviour:
- Reset: state=IDLE, tri=0, del_o=1, del_vld=0. Reset mid-ramp discards all progress.
- States:
  - IDLE: tri held at 0. Next clock with en=1 goes to RISE. No vld_i is required for this transition.
  - RISE: on vld_i, if tri >= MAX-rate then tri=MAX and go to FALL; else tri += rate.
  - FALL: on vld_i, if tri <= rate then tri=0 and go to RISE; else tri -= rate.
- Step rules:
  - rate=0 freezes tri and state; no transition in either RISE or FALL.
  - en=0 in any state: next clock tri=0, state=IDLE. en=0 takes priority over a simultaneous vld_i.
  - rate, depth and base are sampled at use. Changes take effect on the next vld_i with no glitch reset of tri.
- Output arithmetic, all unsigned:
  - offset = (tri * depth) >> ACC_WIDTH, using a full ACC_WIDTH+DEL_WIDTH product; offset is always < 2^DEL_WIDTH.
  - sum = base + offset in DEL_WIDTH+1 bits.
  - If sum > BUFR_DEPTH-1, del_o = BUFR_DEPTH-1. Else if sum < 1, del_o = 1. Else del_o = sum.
- Timing:
  - vld_i sampled high at edge N updates tri at edge N.
  - del_o and del_vld are registered at edge N+1 from the new tri.
  - del_vld is high for exactly one cycle per vld_i, including while in IDLE (del_o = clamp(base)).
- Back-to-back vld_i on consecutive cycles is legal; each produces its own update and pulse.
- No other outputs are combinational from inputs.

Optional Feature:
- Macro: DEL_LFO_SLEW_LIMIT_EN.
- Defined:
  - An internal target register receives the clamped sum.
  - On each update, del_o moves toward the target by at most 1: +1 if target > del_o, -1 if target < del_o, else hold.
  - Bounds on del_o still apply. del_vld timing is unchanged.
  - Reset sets del_o=1, so the output ramps up to base one step per sample.
- Undefined: del_o = clamped sum directly, as specified above.

Test Plan:
- Reset, then ACC_WIDTH=8, en=1, rate=64, depth=100, base=200, 10 vld_i pulses:
  - tri = 64,128,192,255,191,127,63,0,64,128.
  - del_o = 225,250,275,299,274,249,224,200,225,250.
  - Each del_o appears with del_vld one cycle after its vld_i.
- Saturation: base=500, depth=100, tri reaching 255 (ACC_WIDTH=8) -> del_o=511, never wraps. Floor: base=0, en=0 -> del_o=1.
- rate=0 with en=1 over 20 vld_i -> del_o constant at base, 20 del_vld pulses, state unchanged.
- en dropped mid-FALL (tri=191) together with a vld_i -> next clock IDLE, tri=0. Next del_vld shows clamp(base). en re-asserted -> ramp restarts at 64.
- rst asserted for one cycle mid-RISE -> next cycle del_o=1, del_vld=0, state=IDLE. With en=1, the first vld_i yields tri=rate.
- DEL_LFO_SLEW_LIMIT_EN defined, base=10, en=0, after reset: del_o = 2,3,…,10 on successive del_vld pulses, then holds at 10.

Source files
------------

// File: rtl/del_lfo_if.sv
// Sample-domain bus between the control registers, the LFO and the delay line.
interface del_lfo_if #(
  parameter int DEL_WIDTH  = 9,
  parameter int RATE_WIDTH = 8
);
  logic                  vld_i;
  logic                  en;
  logic [RATE_WIDTH-1:0] rate;
  logic [DEL_WIDTH-1:0]  depth;
  logic [DEL_WIDTH-1:0]  base;
  logic [DEL_WIDTH-1:0]  del_o;
  logic                  del_vld;

  modport master (output vld_i, en, rate, depth, base, input del_o, del_vld);
  modport slave  (input vld_i, en, rate, depth, base, output del_o, del_vld);
endinterface

// File: rtl/del_lfo.sv
// Triangle LFO delay modulator: tri scaled by depth plus base, clamped to [1, BUFR_DEPTH-1].
// Optional macro DEL_LFO_SLEW_LIMIT_EN limits del_o to one sample of change per update.
module del_lfo #(
  parameter int BUFR_DEPTH = 512,
  parameter int ACC_WIDTH  = 16,
  parameter int RATE_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  del_lfo_if.slave bus
);
  localparam int DEL_WIDTH = $clog2(BUFR_DEPTH);
  localparam int SW = ((ACC_WIDTH > RATE_WIDTH) ? ACC_WIDTH : RATE_WIDTH) + 1;
  localparam logic [ACC_WIDTH-1:0] MAX = '1;
  localparam logic [SW-1:0] MAX_W = SW'(MAX);
  localparam logic [DEL_WIDTH:0] LIM = (DEL_WIDTH+1)'(BUFR_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;

  state_t                          state;
  logic [ACC_WIDTH-1:0]            tri_acc;
  logic                            pend;
  logic [SW-1:0]                   tri_w;
  logic [SW-1:0]                   rate_w;
  logic [ACC_WIDTH+DEL_WIDTH-1:0]  prod;
  logic [DEL_WIDTH-1:0]            offset;
  logic [DEL_WIDTH:0]              sum;
  logic [DEL_WIDTH-1:0]            target;

  assign tri_w  = SW'(tri_acc);
  assign rate_w = SW'(bus.rate);
  assign prod   = {{DEL_WIDTH{1'b0}}, tri_acc} * {{ACC_WIDTH{1'b0}}, bus.depth};
  assign offset = DEL_WIDTH'(prod >> ACC_WIDTH);
  assign sum    = {1'b0, bus.base} + {1'b0, offset};

  always_comb begin
    target = DEL_WIDTH'(sum);
    if (sum > LIM)
      target = LIM[DEL_WIDTH-1:0];
    else if (sum == '0)
      target = DEL_WIDTH'(1);
  end

  // pend delays the update one cycle so the output sees the freshly stepped tri
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tri_acc     <= '0;
      pend        <= 1'b0;
      bus.del_o   <= DEL_WIDTH'(1);
      bus.del_vld <= 1'b0;
    end else begin
      pend        <= bus.vld_i;
      bus.del_vld <= pend;
      if (pend) begin
`ifdef DEL_LFO_SLEW_LIMIT_EN
        if (target > bus.del_o)
          bus.del_o <= bus.del_o + DEL_WIDTH'(1);
        else if (target < bus.del_o)
          bus.del_o <= bus.del_o - DEL_WIDTH'(1);
`else
        bus.del_o <= target;
`endif
      end

      if (!bus.en) begin
        state   <= IDLE;
        tri_acc <= '0;
      end else begin
        case (state)
          IDLE: state <= RISE;
          RISE: begin
            if (bus.vld_i && bus.rate != '0) begin
              if (tri_w + rate_w >= MAX_W) begin
                tri_acc <= MAX;
                state   <= FALL;
              end else begin
                tri_acc <= tri_acc + ACC_WIDTH'(bus.rate);
              end
            end
          end
          FALL: begin
            if (bus.vld_i && bus.rate != '0) begin
              if (tri_w <= rate_w) begin
                tri_acc <= '0;
                state   <= RISE;
              end else begin
                tri_acc <= tri_acc - ACC_WIDTH'(bus.rate);
              end
            end
          end
          default: begin
            state   <= IDLE;
            tri_acc <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_del_lfo.sv
// Directed bench for del_lfo with ACC_WIDTH=8, BUFR_DEPTH=512, RATE_WIDTH=8.
module tb_del_lfo;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  del_lfo_if #(.DEL_WIDTH(9), .RATE_WIDTH(8)) bus ();

  del_lfo #(.BUFR_DEPTH(512), .ACC_WIDTH(8), .RATE_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one isolated vld_i: no pulse on the cycle after the tri update, pulse with value one cycle later
  task automatic do_vld(input string tag, input int exp);
    bus.vld_i = 1'b1;
    tick();
    bus.vld_i = 1'b0;
    chk({tag, "_early"}, 16'(bus.del_vld), 16'd0);
    tick();
    chk({tag, "_vld"}, 16'(bus.del_vld), 16'd1);
    chk({tag, "_del"}, 16'(bus.del_o), 16'(exp));
  endtask

  initial begin
    int ramp [10];
    ramp = '{225, 250, 275, 299, 274, 249, 224, 200, 225, 250};
    rst = 1'b1;
    bus.vld_i = 1'b0;
    bus.en = 1'b0;
    bus.rate = 8'd64;
    bus.depth = 9'd100;
    bus.base = 9'd200;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_del", 16'(bus.del_o), 16'd1);
    chk("reset_vld", 16'(bus.del_vld), 16'd0);

`ifdef DEL_LFO_SLEW_LIMIT_EN
    bus.base = 9'd10;
    bus.depth = 9'd0;
    for (int i = 2; i <= 12; i++)
      do_vld("slew", (i > 10) ? 10 : i);
`else
    // triangle ramp
    bus.en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++)
      do_vld("ramp", ramp[i]);

    // climb to 255, fall to 191, then drop en together with vld_i
    do_vld("pre_fall", 275);
    do_vld("peak", 299);
    do_vld("fall191", 274);
    bus.en = 1'b0;
    do_vld("en_drop", 200);
    bus.en = 1'b1;
    tick();
    do_vld("restart", 225);

    // one-cycle reset mid-RISE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_del", 16'(bus.del_o), 16'd1);
    chk("midrst_vld", 16'(bus.del_vld), 16'd0);
    tick();
    do_vld("after_rst", 225);

    // saturation at the buffer top
    bus.base = 9'd500;
    do_vld("sat128", 511);
    do_vld("sat192", 511);
    do_vld("sat255", 511);

    // floor clamp
    bus.base = 9'd0;
    bus.en = 1'b0;
    do_vld("floor", 1);

    // frozen LFO
    bus.base = 9'd200;
    bus.rate = 8'd0;
    bus.en = 1'b1;
    tick();
    for (int i = 0; i < 20; i++)
      do_vld("rate0", 200);

    // back-to-back strobes after re-enabling the step
    bus.rate = 8'd64;
    bus.vld_i = 1'b1;
    tick();
    tick();
    bus.vld_i = 1'b0;
    chk("b2b_vld0", 16'(bus.del_vld), 16'd1);
    chk("b2b_del0", 16'(bus.del_o), 16'd225);
    tick();
    chk("b2b_vld1", 16'(bus.del_vld), 16'd1);
    chk("b2b_del1", 16'(bus.del_o), 16'd250);
    tick();
    chk("b2b_end", 16'(bus.del_vld), 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
